rgb_pwm_periph: RTL and testbench

Memory-mapped LED/RGB peripheral between the core's data-memory bus and the board's LED pins. It provides per-channel 8-bit PWM brightness for red/green/blue, a plain LED bit, and a free-running millisecond counter. Glitch-free duty updates come from shadow registers loaded at PWM period boundaries. Outputs are active-high; the top level inverts them for the active-low pins.

---
 rtl/rgb_pwm_periph.sv | 160 ++++++++++++++++
 tb/tb_rgb_pwm_periph.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_periph.sv
// Memory-mapped RGB/LED peripheral: three 8-bit PWM channels with period-aligned
// shadow duties, a plain LED bit, and a free-running millisecond counter.
module rgb_pwm_periph #(
   parameter int unsigned CLK_HZ = 12_000_000,
   parameter int unsigned MS_DIV = CLK_HZ / 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic        wren,
   input  logic [7:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        red,
   output logic        green,
   output logic        blue,
   output logic        led
);

   typedef enum logic [5:0] {
      REG_DUTY_R   = 6'd0,
      REG_DUTY_G   = 6'd1,
      REG_DUTY_B   = 6'd2,
      REG_CTRL     = 6'd3,
      REG_PRESCALE = 6'd4,
      REG_MILLIS   = 6'd5
   } reg_idx_e;

   localparam int unsigned    MSW     = $clog2(MS_DIV);
   localparam logic [MSW-1:0] MS_LAST = MSW'(MS_DIV - 1);
   localparam logic [MSW-1:0] MS_ONE  = MSW'(1);

   logic [7:0]     duty_r_q, duty_r_d, duty_g_q, duty_g_d, duty_b_q, duty_b_d;
   logic [7:0]     shadow_r_q, shadow_r_d, shadow_g_q, shadow_g_d, shadow_b_q, shadow_b_d;
   logic [1:0]     ctrl_q, ctrl_d;
   logic [15:0]    prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;
   logic [7:0]     pwm_cnt_q, pwm_cnt_d;
   logic [MSW-1:0] ms_cnt_q, ms_cnt_d;
   logic [31:0]    millis_q, millis_d, rdata_q, rdata_d, rd_val;
   logic           red_q, red_d, green_q, green_d, blue_q, blue_d, led_q, led_d;
   logic           tick;

   reg_idx_e idx;
   logic     unused_addr;
   assign idx         = reg_idx_e'(addr[7:2]);
   assign unused_addr = ^addr[1:0];

   always_comb begin
      duty_r_d   = duty_r_q;
      duty_g_d   = duty_g_q;
      duty_b_d   = duty_b_q;
      shadow_r_d = shadow_r_q;
      shadow_g_d = shadow_g_q;
      shadow_b_d = shadow_b_q;
      ctrl_d     = ctrl_q;
      prescale_d = prescale_q;
      pre_cnt_d  = pre_cnt_q;
      pwm_cnt_d  = pwm_cnt_q;
      ms_cnt_d   = ms_cnt_q;
      millis_d   = millis_q;
      rdata_d    = rdata_q;
      rd_val     = '0;
      tick       = (pre_cnt_q == prescale_q);

      case (idx)
         REG_DUTY_R:   rd_val = 32'(duty_r_q);
         REG_DUTY_G:   rd_val = 32'(duty_g_q);
         REG_DUTY_B:   rd_val = 32'(duty_b_q);
         REG_CTRL:     rd_val = 32'(ctrl_q);
         REG_PRESCALE: rd_val = 32'(prescale_q);
         REG_MILLIS:   rd_val = millis_q;
         default:      rd_val = '0;
      endcase
      if (sel) rdata_d = rd_val;

      // A PRESCALE shrunk below the running count restarts the prescaler without a tick.
      if (tick || (pre_cnt_q > prescale_q)) pre_cnt_d = '0;
      else                                   pre_cnt_d = pre_cnt_q + 16'd1;

      if (tick) begin
         pwm_cnt_d = pwm_cnt_q + 8'd1;
         if (pwm_cnt_q == 8'hFF) begin
            shadow_r_d = duty_r_q;
            shadow_g_d = duty_g_q;
            shadow_b_d = duty_b_q;
         end
      end

      red_d   = ctrl_q[0] & (pwm_cnt_q < shadow_r_q);
      green_d = ctrl_q[0] & (pwm_cnt_q < shadow_g_q);
      blue_d  = ctrl_q[0] & (pwm_cnt_q < shadow_b_q);
      led_d   = ctrl_q[1];

      if (ms_cnt_q == MS_LAST) begin
         ms_cnt_d = '0;
         millis_d = millis_q + 32'd1;
      end else begin
         ms_cnt_d = ms_cnt_q + MS_ONE;
      end

      if (sel && wren) begin
         case (idx)
            REG_DUTY_R:   duty_r_d   = wdata[7:0];
            REG_DUTY_G:   duty_g_d   = wdata[7:0];
            REG_DUTY_B:   duty_b_d   = wdata[7:0];
            REG_CTRL:     ctrl_d     = wdata[1:0];
            REG_PRESCALE: prescale_d = wdata[15:0];
            REG_MILLIS:   millis_d   = wdata;
            default:      ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         duty_r_q   <= '0;
         duty_g_q   <= '0;
         duty_b_q   <= '0;
         shadow_r_q <= '0;
         shadow_g_q <= '0;
         shadow_b_q <= '0;
         ctrl_q     <= '0;
         prescale_q <= '0;
         pre_cnt_q  <= '0;
         pwm_cnt_q  <= '0;
         ms_cnt_q   <= '0;
         millis_q   <= '0;
         rdata_q    <= '0;
         red_q      <= 1'b0;
         green_q    <= 1'b0;
         blue_q     <= 1'b0;
         led_q      <= 1'b0;
      end else begin
         duty_r_q   <= duty_r_d;
         duty_g_q   <= duty_g_d;
         duty_b_q   <= duty_b_d;
         shadow_r_q <= shadow_r_d;
         shadow_g_q <= shadow_g_d;
         shadow_b_q <= shadow_b_d;
         ctrl_q     <= ctrl_d;
         prescale_q <= prescale_d;
         pre_cnt_q  <= pre_cnt_d;
         pwm_cnt_q  <= pwm_cnt_d;
         ms_cnt_q   <= ms_cnt_d;
         millis_q   <= millis_d;
         rdata_q    <= rdata_d;
         red_q      <= red_d;
         green_q    <= green_d;
         blue_q     <= blue_d;
         led_q      <= led_d;
      end
   end

   assign rdata = rdata_q;
   assign red   = red_q;
   assign green = green_q;
   assign blue  = blue_q;
   assign led   = led_q;

endmodule

// File: tb/tb_rgb_pwm_periph.sv
// Bench for rgb_pwm_periph: behavioural model compared every cycle, plus
// directed duty/period/MILLIS/decode scenarios with literal expectations.
module tb_rgb_pwm_periph;

   localparam int unsigned MS_DIV = 4;

   logic        clk = 1'b0;
   logic        reset, sel, wren;
   logic [7:0]  addr;
   logic [31:0] wdata, rdata;
   logic        red, green, blue, led;

   rgb_pwm_periph #(.MS_DIV(MS_DIV)) dut (
      .clk(clk), .reset(reset), .sel(sel), .wren(wren), .addr(addr),
      .wdata(wdata), .rdata(rdata), .red(red), .green(green), .blue(blue), .led(led)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mask_of(input int unsigned i);
      case (i)
         0, 1, 2: return 32'hFF;
         3:       return 32'h3;
         4:       return 32'hFFFF;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   // Behavioural model: register file array, prescale phase, PWM step, ms phase.
   logic [31:0] m_reg [6];
   logic [7:0]  m_sh  [3];
   int unsigned m_pre, m_step, m_ms;
   logic [2:0]  m_out;
   logic        m_led;
   logic [31:0] m_rdata;
   bit          m_valid = 0;

   always @(posedge clk) begin : model
      int unsigned idx;
      int unsigned pscl;
      logic [2:0]  n_out;
      if (reset) begin
         for (int i = 0; i < 6; i++) m_reg[i] = 0;
         for (int c = 0; c < 3; c++) m_sh[c] = 0;
         m_pre = 0; m_step = 0; m_ms = 0;
         m_out = 0; m_led = 0; m_rdata = 0;
         m_valid = 1;
      end else if (m_valid) begin
         idx = int'(addr[7:2]);
         for (int c = 0; c < 3; c++) n_out[c] = m_reg[3][0] && (m_step < int'(m_sh[c]));
         m_out = n_out;
         m_led = m_reg[3][1];
         if (sel) m_rdata = (idx < 6) ? m_reg[idx] : 32'h0;
         pscl = m_reg[4];
         if (m_pre == pscl) begin
            m_pre = 0;
            if (m_step == 255)
               for (int c = 0; c < 3; c++) m_sh[c] = m_reg[c][7:0];
            m_step = (m_step + 1) % 256;
         end else if (m_pre > pscl) begin
            m_pre = 0;
         end else begin
            m_pre = m_pre + 1;
         end
         if (m_ms == MS_DIV - 1) begin
            m_ms = 0;
            m_reg[5] = m_reg[5] + 32'd1;
         end else begin
            m_ms = m_ms + 1;
         end
         if (sel && wren && idx < 6) m_reg[idx] = wdata & mask_of(idx);
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("cyc_red",   {31'h0, red},   {31'h0, m_out[0]});
         check("cyc_green", {31'h0, green}, {31'h0, m_out[1]});
         check("cyc_blue",  {31'h0, blue},  {31'h0, m_out[2]});
         check("cyc_led",   {31'h0, led},   {31'h0, m_led});
         check("cyc_rdata", rdata, m_rdata);
      end
   end

   task automatic bus(input logic s, input logic w, input logic [7:0] a, input logic [31:0] d);
      sel = s; wren = w; addr = a; wdata = d;
      @(negedge clk);
      sel = 1'b0; wren = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete, got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int cr, cg, cb, cr2, k;
      logic [5:0] a6;
      reset = 1'b1; sel = 1'b0; wren = 1'b0; addr = '0; wdata = '0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         sel = 1'b1; wren = 1'b1; addr = 8'($urandom); wdata = $urandom;
         @(negedge clk);
      end
      reset = 1'b0; sel = 1'b0; wren = 1'b0;
      check("rst_outputs", {27'h0, red, green, blue, led, 1'b0}, 32'h0);
      check("rst_rdata", rdata, 32'h0);

      bus(1, 0, 8'h14, 0);
      check("rst_millis", rdata, 32'h0);
      for (int i = 0; i < 5; i++) begin
         bus(1, 0, 8'(i * 4), 0);
         check("rst_reg_read", rdata, 32'h0);
      end
      idle(14);
      bus(1, 0, 8'h14, 0);
      check("millis_after_20", rdata, 32'd5);

      bus(1, 1, 8'h14, 32'hFFFF_FFFF);
      idle(4);
      bus(1, 0, 8'h14, 0);
      check("millis_wrap", rdata, 32'h0);
      k = 0;
      while (k < 8 && m_ms != MS_DIV - 1) begin
         @(negedge clk);
         k++;
      end
      check("ms_phase_found", m_ms, MS_DIV - 1);
      bus(1, 1, 8'h14, 32'h1234_5678);
      bus(1, 0, 8'h14, 0);
      check("millis_write_on_tick", rdata, 32'h1234_5678);

      bus(1, 0, 8'h18, 0);
      check("read_unmapped", rdata, 32'h0);
      bus(1, 1, 8'h18, 32'hDEAD_BEEF);
      bus(1, 0, 8'h18, 0);
      check("write_unmapped_ignored", rdata, 32'h0);
      bus(1, 1, 8'h0C, 32'hFFFF_FFFF);
      bus(1, 0, 8'h0C, 0);
      check("ctrl_readback", rdata, 32'h3);
      check("led_on", {31'h0, led}, 32'h1);
      bus(1, 1, 8'h00, 32'h11);
      bus(1, 1, 8'h00, 32'hFFFF_FF55);
      check("read_during_write_old", rdata, 32'h11);
      bus(1, 0, 8'h00, 0);
      check("read_after_write_new", rdata, 32'h55);
      bus(1, 0, 8'h01, 0);
      check("addr_low_bits_ignored", rdata, 32'h55);

      bus(1, 1, 8'h0C, 32'h1);
      bus(1, 1, 8'h10, 32'h0);
      bus(1, 1, 8'h00, 32'd64);
      bus(1, 1, 8'h04, 32'd0);
      bus(1, 1, 8'h08, 32'd255);
      idle(300);
      k = 0;
      while (k < 300 && m_step != 1) begin
         @(negedge clk);
         k++;
      end
      check("pwm_align_found", m_step, 32'd1);
      cr = 0; cg = 0; cb = 0; cr2 = 0;
      for (int i = 0; i < 512; i++) begin
         if (i < 256) begin
            cr += int'(red); cg += int'(green); cb += int'(blue);
         end else begin
            cr2 += int'(red);
         end
         if (i == 99) begin
            sel = 1'b1; wren = 1'b1; addr = 8'h00; wdata = 32'd200;
         end else if (i == 100) begin
            sel = 1'b0; wren = 1'b0;
         end
         @(negedge clk);
      end
      check("red_duty64_current_period", cr, 32'd64);
      check("green_duty0", cg, 32'd0);
      check("blue_duty255", cb, 32'd255);
      check("red_duty200_next_period", cr2, 32'd200);

      bus(1, 1, 8'h10, 32'd3);
      bus(1, 1, 8'h04, 32'd128);
      idle(2200);
      cg = 0;
      for (int i = 0; i < 1024; i++) begin
         cg += int'(green);
         @(negedge clk);
      end
      check("green_presc3_high", cg, 32'd512);
      bus(1, 1, 8'h0C, 32'h0);
      idle(1);
      check("green_low_after_en_clear", {31'h0, green}, 32'h0);
      cg = 0;
      for (int i = 0; i < 100; i++) begin
         cg += int'(green);
         @(negedge clk);
      end
      check("green_stays_low_disabled", cg, 32'd0);
      bus(1, 1, 8'h0C, 32'h1);
      idle(1);
      cg = 0;
      for (int i = 0; i < 1024; i++) begin
         cg += int'(green);
         @(negedge clk);
      end
      check("green_resumed_high", cg, 32'd512);

      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 599) == 0);
         a6    = 6'($urandom_range(0, 7));
         sel   = ($urandom_range(0, 3) == 0);
         wren  = 1'($urandom);
         addr  = {a6, 2'($urandom)};
         wdata = $urandom;
         if (a6 == 6'd4) wdata = 32'($urandom_range(0, 6)) | (32'($urandom) & 32'hFFFF_0000);
         @(negedge clk);
      end
      reset = 1'b0; sel = 1'b0; wren = 1'b0;
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
